// File: rtl/pixel_pkg.sv
// Shared constants and FSM encoding for the pixel fetch path.
// Packed RGB: 4 pixels of 3 bytes fill 3 words of 4 bytes.
package pixel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ISSUE,
    S_WAIT_P,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int BYTES_PER_PIX   = 3;
  localparam int BYTES_PER_WORD  = 4;
  localparam int WORDS_PER_GROUP = 3;
  localparam int PIX_PER_GROUP   = 4;

  // Slot index of the last read in a group, and of the hold slot after it.
  localparam logic [1:0] LAST_RD_SLOT = 2'(WORDS_PER_GROUP - 1);
  localparam logic [1:0] HOLD_SLOT    = 2'(WORDS_PER_GROUP);

endpackage

// File: rtl/pixel_lat_pipe.sv
// Fixed-depth 1-bit delay line with synchronous clear; mirrors BRAM read latency.
module lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign q = vld_pipe[DEPTH-1];

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Issues BRAM word reads for a packed-RGB job (RRRH per group) and tracks
// pixels emitted by pixel_concat until the job's pixel count is reached.
module pixel_fetch_ctrl
  import pixel_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 20,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  npix,
  input  logic                  pause,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  cat_rst,
  output logic                  cat_ival,
  input  logic                  cat_oval,
  output logic                  busy,
  output logic                  done
);

  localparam int WW = CNT_WIDTH + 2;

  state_t               state;
  logic [1:0]           slot;
  logic [WW-1:0]        words;
  logic [WW-1:0]        wcnt;
  logic [WW-1:0]        words_calc;
  logic [CNT_WIDTH-1:0] npix_r;
  logic [CNT_WIDTH-1:0] pcnt;
  logic [CNT_WIDTH-1:0] pcnt_nxt;
  logic                 cnt_en;
  logic                 last_word;

  // ceil(npix*3/4) with headroom so the multiply cannot overflow
  assign words_calc = ({2'b00, npix} * WW'(BYTES_PER_PIX) + WW'(BYTES_PER_WORD - 1))
                      >> $clog2(BYTES_PER_WORD);

  assign last_word = (wcnt == words);
  // Tail bytes of a partial last word may produce extra oval; cap at npix.
  assign cnt_en    = cat_oval && busy && (pcnt != npix_r);
  assign pcnt_nxt  = pcnt + CNT_WIDTH'(cnt_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      slot      <= '0;
      words     <= '0;
      wcnt      <= '0;
      npix_r    <= '0;
      pcnt      <= '0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      cat_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      cat_rst <= 1'b0;
      pcnt    <= pcnt_nxt;
      case (state)
        S_IDLE: if (start) begin
          state     <= S_INIT;
          cat_rst   <= 1'b1;
          busy      <= 1'b1;
          bram_addr <= base_addr;
          words     <= words_calc;
          npix_r    <= npix;
          pcnt      <= '0;
          wcnt      <= '0;
        end
        S_INIT: if (npix_r == '0) begin
          state <= S_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          state   <= S_ISSUE;
          bram_en <= 1'b1;
          slot    <= '0;
          wcnt    <= WW'(1);
        end
        S_ISSUE: begin
          if (slot == HOLD_SLOT) begin
            // Group boundary: the only place pause is honoured.
            if (last_word) begin
              state <= S_DRAIN;
            end else if (pause) begin
              state <= S_WAIT_P;
            end else begin
              slot      <= '0;
              bram_en   <= 1'b1;
              bram_addr <= bram_addr + 1'b1;
              wcnt      <= wcnt + 1'b1;
            end
          end else if (slot == LAST_RD_SLOT) begin
            // Hold address so dout stays on word 3k+2 for pixel 4k+3.
            bram_en <= 1'b0;
            slot    <= HOLD_SLOT;
          end else if (last_word) begin
            bram_en <= 1'b0;
            state   <= S_DRAIN;
          end else begin
            slot      <= slot + 2'd1;
            bram_addr <= bram_addr + 1'b1;
            wcnt      <= wcnt + 1'b1;
          end
        end
        S_WAIT_P: if (!pause) begin
          state     <= S_ISSUE;
          slot      <= '0;
          bram_en   <= 1'b1;
          bram_addr <= bram_addr + 1'b1;
          wcnt      <= wcnt + 1'b1;
        end
        S_DRAIN: if (pcnt_nxt == npix_r) begin
          state <= S_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  lat_pipe #(.DEPTH(RD_LAT)) u_lat_pipe (
    .clk (clk),
    .rst (rst),
    .d   (bram_en),
    .q   (cat_ival)
  );

endmodule
